// File: rtl/i2s_sound_tx_if.sv
// I2S sound transmitter bundle: filtered sample in, serial DAC stream out.
// master is the transmitter side, slave is the sample source / DAC side.
interface i2s_sound_tx_if;
  logic [14:0] inSound;
  logic        mute;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic        sample_strobe;

  modport master (
    input  inSound,
    input  mute,
    output i2s_bclk,
    output i2s_lrclk,
    output i2s_sdata,
    output sample_strobe
  );

  modport slave (
    output inSound,
    output mute,
    input  i2s_bclk,
    input  i2s_lrclk,
    input  i2s_sdata,
    input  sample_strobe
  );
endinterface

// File: rtl/i2s_sound_tx.sv
// Philips I2S transmitter: mono 15-bit unsigned sample sent as signed
// 16-bit on both 32-bit slots, BCLK/LRCLK derived from the system clock.
module i2s_sound_tx #(
  parameter int clkspeed   = 27000000,
  parameter int samplerate = 48000
) (
  input logic           clk,
  input logic           reset,
  i2s_sound_tx_if.master bus
);
  localparam int HALF = clkspeed / (samplerate * 128);
  localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;

  generate
    if (HALF < 1) begin : g_bad_half
      $error("i2s_sound_tx: clkspeed too low for samplerate");
    end
  endgenerate

  localparam logic [DW-1:0] LAST = DW'(HALF - 1);

  logic [DW-1:0] divcnt;
  logic          bclk;
  logic          lrclk;
  logic          sdata;
  logic          strobe;
  logic [5:0]    bitcnt;
  logic [15:0]   hold;

  logic          tick;
  logic          fall;
  logic [5:0]    nxt;
  logic [3:0]    idx;
  logic          in_slot;
  logic          nxt_sdata;
  logic [15:0]   word;

  always_comb begin
    tick      = (divcnt == LAST);
    fall      = tick & bclk;
    nxt       = bitcnt + 6'd1;
    // slot bit n maps to hold[16-n] (left) / hold[48-n] (right)
    idx       = 4'd0 - nxt[3:0];
    in_slot   = (nxt[4:0] != 5'd0) && (nxt[4:0] <= 5'd16);
    nxt_sdata = in_slot & hold[idx];
    word      = 16'h0000;
    if (!bus.mute)
      word = {~bus.inSound[14], bus.inSound[13:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      divcnt <= '0;
      bclk   <= 1'b0;
      bitcnt <= 6'd63;
      lrclk  <= 1'b1;
      sdata  <= 1'b0;
      strobe <= 1'b0;
      hold   <= 16'h0000;
    end else begin
      strobe <= 1'b0;
      if (tick) begin
        divcnt <= '0;
        bclk   <= ~bclk;
      end else begin
        divcnt <= divcnt + 1'b1;
      end
      if (fall) begin
        bitcnt <= nxt;
        lrclk  <= nxt[5];
        sdata  <= nxt_sdata;
        if (nxt == 6'd0) begin
          hold   <= word;
          strobe <= 1'b1;
        end
      end
    end
  end

  assign bus.i2s_bclk      = bclk;
  assign bus.i2s_lrclk     = lrclk;
  assign bus.i2s_sdata     = sdata;
  assign bus.sample_strobe = strobe;
endmodule

// File: tb/tb_i2s_sound_tx.sv
// Bench for i2s_sound_tx: cycle-exact timing model plus slot-word capture
// on BCLK rise, directed and random sample/mute patterns, mid-frame reset.
module tb_i2s_sound_tx;
  localparam int CLKSPEED = 12288000;
  localparam int SRATE    = 48000;
  localparam int H        = 2;
  localparam int FRAME    = 128 * H;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [14:0] in_sound = 15'h0;
  logic mute = 1'b0;

  int compared = 0;
  int mismatched = 0;
  int t = 0;
  logic [15:0] exp_word = 16'h0000;
  logic [15:0] sr = 16'h0000;

  i2s_sound_tx_if bus ();
  assign bus.inSound = in_sound;
  assign bus.mute    = mute;

  i2s_sound_tx #(
    .clkspeed  (CLKSPEED),
    .samplerate(SRATE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] conv(input logic [14:0] s, input logic m);
    int v;
    v = (int'(s) - 16384) * 2;
    return m ? 16'h0000 : 16'(v);
  endfunction

  function automatic int bit_of(input int tt);
    if (tt < 2 * H) return 63;
    return ((tt - 2 * H) / (2 * H)) % 64;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    compared++;
    assert (got === exp)
    else begin
      mismatched++;
      $error("FAIL %s t=%0d got %h exp %h", tag, t, got, exp);
    end
  endtask

  task automatic step();
    int n;
    logic e_sd;
    @(posedge clk);
    t++;
    if (t >= 2 * H && (t - 2 * H) % FRAME == 0)
      exp_word = conv(in_sound, mute);
    #1;
    n = bit_of(t);
    e_sd = 1'b0;
    if (n >= 1 && n <= 16) e_sd = exp_word[16 - n];
    if (n >= 33 && n <= 48) e_sd = exp_word[48 - n];
    chk("bclk", 16'(bus.i2s_bclk), 16'((t / H) % 2));
    chk("lrclk", 16'(bus.i2s_lrclk), 16'(n >= 32));
    chk("sdata", 16'(bus.i2s_sdata), 16'(e_sd));
    chk("strobe", 16'(bus.sample_strobe),
        16'(t >= 2 * H && (t - 2 * H) % FRAME == 0));
    if (t % (2 * H) == H) begin
      if ((n >= 1 && n <= 16) || (n >= 33 && n <= 48))
        sr = {sr[14:0], bus.i2s_sdata};
      if (n == 16) chk("left_word", sr, exp_word);
      if (n == 48) chk("right_word", sr, exp_word);
    end
  endtask

  task automatic run_until(input int tt);
    while (t < tt) step();
  endtask

  function automatic int lat(input int f);
    return 2 * H + FRAME * f;
  endfunction

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_bclk", 16'(bus.i2s_bclk), 16'd0);
      chk("rst_lrclk", 16'(bus.i2s_lrclk), 16'd1);
      chk("rst_sdata", 16'(bus.i2s_sdata), 16'd0);
      chk("rst_strobe", 16'(bus.sample_strobe), 16'd0);
    end
    reset = 1'b0;
    t = 0;

    in_sound = 15'h7FFF;
    run_until(lat(1) - 10);
    in_sound = 15'h0000;
    run_until(lat(2) - 10);
    in_sound = 15'h4000;
    run_until(lat(3) - 10);
    in_sound = 15'h0001;
    run_until(lat(4) - 10);
    in_sound = 15'h1234;
    run_until(lat(4) + 20 * 2 * H);
    in_sound = 15'h7000;
    run_until(lat(6) - 10);

    in_sound = 15'h7FFF;
    mute = 1'b1;
    run_until(lat(6) + 20);
    mute = 1'b0;
    run_until(lat(7) + 100);
    mute = 1'b1;
    run_until(lat(7) + 150);
    mute = 1'b0;
    run_until(lat(8) - 10);

    for (int i = 0; i < 40; i++) begin
      in_sound = 15'($urandom);
      mute = ($urandom_range(0, 3) == 0);
      run_until(t + int'($urandom_range(1, 100)));
    end
    mute = 1'b0;

    while ((t - 2 * H) % FRAME != 40 * 2 * H) step();
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_bclk", 16'(bus.i2s_bclk), 16'd0);
    chk("mid_rst_lrclk", 16'(bus.i2s_lrclk), 16'd1);
    chk("mid_rst_sdata", 16'(bus.i2s_sdata), 16'd0);
    chk("mid_rst_strobe", 16'(bus.sample_strobe), 16'd0);
    reset = 1'b0;
    t = 0;
    sr = 16'h0000;
    in_sound = 15'h2AAA;
    run_until(lat(1) - 10);
    in_sound = 15'h5555;
    run_until(lat(2) + 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
